// File: rtl/cordic_pkg.sv
// Shared types and constants for the linear-mode CORDIC multiply-accumulate.
// Holds the sequencer state encoding, default fixed-point constants and the counter-width helper.
package cordic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      Y_UPD = 2'd1,
      Z_UPD = 2'd2,
      DONE  = 2'd3
   } lin_mac_state_t;

   localparam int DEF_FRAC  = 13;
   localparam int DEF_ITERS = 14;

   // Never returns less than 1 so a single-iteration build still has a counter bit.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/cordic_lin_mac_seq_add_sub.sv
// Shared adder/subtractor for the CORDIC sequencer: out = sel ? a - b : a + b.
// Wraps modulo 2^(WIDTH+1).
module add_sub #(
   parameter int WIDTH = 15
) (
   input  logic signed [WIDTH:0] a,
   input  logic signed [WIDTH:0] b,
   input  logic                  sel,
   output logic signed [WIDTH:0] out
);

   assign out = sel ? (a - b) : (a + b);

endmodule

// File: rtl/cordic_lin_mac_seq.sv
// Iterative linear-mode CORDIC MAC, y = acc + x*z, with one adder shared between
// the y-update and z-update phases of every iteration.
module cordic_lin_mac_seq
   import cordic_pkg::*;
#(
   parameter int WIDTH = 15,
   parameter int FRAC  = DEF_FRAC,
   parameter int ITERS = DEF_ITERS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic signed [WIDTH:0] x_in,
   input  logic signed [WIDTH:0] z_in,
   input  logic signed [WIDTH:0] acc_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic signed [WIDTH:0] y_out,
   output logic signed [WIDTH:0] z_res
);

   localparam int CW = clog2(ITERS);
   localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);
   localparam logic signed [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   if (ITERS < 1 || ITERS > FRAC + 1) begin : g_bad_iters
      $error("cordic_lin_mac_seq: ITERS must lie in 1..FRAC+1");
   end

   lin_mac_state_t state_reg, state_next;

   logic signed [WIDTH:0] x_reg, y_reg, z_reg;
   logic signed [WIDTH:0] y_out_reg, z_res_reg;
   logic                  d_reg;
   logic [CW-1:0]         iter_reg;
   logic                  run_reg;
   logic                  last_iter;

   logic signed [WIDTH:0] add_a, add_b, add_out;
   logic                  add_sel;

   assign last_iter = (iter_reg == LAST_ITER);
   assign y_out     = y_out_reg;
   assign z_res     = z_res_reg;

   add_sub #(.WIDTH(WIDTH)) u_add_sub (
      .a   (add_a),
      .b   (add_b),
      .sel (add_sel),
      .out (add_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Operand muxing: y phase adds/subtracts x*2^-i, z phase removes 2^-i from z.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      add_a      = y_reg;
      add_b      = x_reg >>> iter_reg;
      add_sel    = z_reg[WIDTH];
      case (state_reg)
         IDLE: begin
            in_ready = run_reg;
            if (in_valid && run_reg) state_next = Y_UPD;
         end
         Y_UPD: state_next = Z_UPD;
         Z_UPD: begin
            add_a      = z_reg;
            add_b      = ONE << (FRAC - int'(iter_reg));
            add_sel    = ~d_reg;
            state_next = last_iter ? DONE : Y_UPD;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // run_reg keeps in_ready low until the first clock after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_reg     <= '0;
         y_reg     <= '0;
         z_reg     <= '0;
         d_reg     <= 1'b0;
         iter_reg  <= '0;
         y_out_reg <= '0;
         z_res_reg <= '0;
         run_reg   <= 1'b0;
      end else begin
         run_reg <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (in_valid && run_reg) begin
                  x_reg    <= x_in;
                  y_reg    <= acc_in;
                  z_reg    <= z_in;
                  iter_reg <= '0;
               end
            end
            Y_UPD: begin
               y_reg <= add_out;
               d_reg <= z_reg[WIDTH];
            end
            Z_UPD: begin
               z_reg <= add_out;
               if (last_iter) begin
                  y_out_reg <= y_reg;
                  z_res_reg <= add_out;
               end else begin
                  iter_reg <= iter_reg + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_lin_mac_seq.sv
// Directed bench for cordic_lin_mac_seq: latency, accuracy, backpressure,
// back-to-back throughput, mid-operation reset and modular wrap.
module tb_cordic_lin_mac_seq;

   localparam int W = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic signed [W:0] x_in = '0;
   logic signed [W:0] z_in = '0;
   logic signed [W:0] acc_in = '0;
   logic in_ready, out_valid;
   logic signed [W:0] y_out, z_res;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cordic_lin_mac_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .z_in      (z_in),
      .acc_in    (acc_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y_out     (y_out),
      .z_res     (z_res)
   );

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_tol(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp, input int tol);
      logic signed [31:0] d;
      d = obs - exp;
      tests++;
      assert ((d <= tol) && (d >= -tol)) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, in_ready, 1);
   endtask

   // Returns the number of clock edges from the accept edge to out_valid.
   task automatic wait_result(output int lat);
      lat = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_op(input string tag, input logic signed [W:0] x, input logic signed [W:0] z,
                        input logic signed [W:0] acc, input int exp_y, input int tol);
      int lat;
      x_in = x; z_in = z; acc_in = acc; in_valid = 1'b1;
      wait_ready(tag);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x_in = 16'sh5555; z_in = 16'sh1234; acc_in = -16'sd777;
      wait_result(lat);
      check({tag, "_lat"}, lat, 28);
      check_tol({tag, "_y"}, y_out, exp_y, tol);
      check_tol({tag, "_zres"}, z_res, 0, 1);
      $display("[TB] %s x=%0d z=%0d acc=%0d -> y=%0d zres=%0d lat=%0d", tag, x, z, acc, y_out, z_res, lat);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_handoff_valid"}, out_valid, 0);
   endtask

   logic signed [W:0] sx [4] = '{16'sd4096, -16'sd8192, 16'sd8192, 16'sd2000};
   logic signed [W:0] sz [4] = '{16'sd4096, 16'sd6144, -16'sd4096, 16'sd8192};
   logic signed [W:0] sa [4] = '{16'sd0, 16'sd8192, 16'sd100, -16'sd500};
   int               sy [4] = '{2048, 2048, -3996, 1500};

   initial begin
      int lat;
      int t_prev;
      logic signed [W:0] held;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_y_out", y_out, 0);
      check("rst_z_res", z_res, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);

      // Basic products
      do_op("half_sq", 16'sd4096, 16'sd4096, 16'sd0, 2048, 2);
      do_op("neg_x", -16'sd8192, 16'sd6144, 16'sd8192, 2048, 14);
      do_op("z_zero", 16'sd5000, 16'sd0, 16'sd1234, 1234, 14);

      // Backpressure with in_valid held high
      x_in = 16'sd8192; z_in = -16'sd4096; acc_in = 16'sd100; in_valid = 1'b1;
      wait_ready("bp");
      @(posedge clk);
      #1;
      x_in = 16'sd4096; z_in = 16'sd4096; acc_in = 16'sd0;
      wait_result(lat);
      check("bp_lat", lat, 28);
      check_tol("bp_y", y_out, -3996, 14);
      held = y_out;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_y_stable", y_out, held);
         check("bp_in_ready_low", in_ready, 0);
         check("bp_valid_held", out_valid, 1);
      end
      $display("[TB] bp x=8192 z=-4096 acc=100 -> y=%0d held 10 cycles", held);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_after_valid", out_valid, 0);
      check("bp_after_idle", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_second_accepted", in_ready, 0);
      wait_result(lat);
      check("bp2_lat", lat, 28);
      check_tol("bp2_y", y_out, 2048, 2);
      $display("[TB] bp2 x=4096 z=4096 acc=0 -> y=%0d", y_out);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Back-to-back with both handshakes tied high
      in_valid = 1'b1;
      out_ready = 1'b1;
      t_prev = 0;
      for (int k = 0; k < 4; k++) begin
         x_in = sx[k]; z_in = sz[k]; acc_in = sa[k];
         wait_ready("stream");
         @(posedge clk);
         #1;
         wait_result(lat);
         check_tol("stream_y", y_out, sy[k], 14);
         if (k > 0) check("stream_spacing", cyc - t_prev, 30);
         $display("[TB] stream%0d x=%0d z=%0d acc=%0d -> y=%0d at cycle %0d", k, sx[k], sz[k], sa[k], y_out, cyc);
         t_prev = cyc;
      end
      in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;

      // Reset during iteration 5
      x_in = 16'sd8192; z_in = 16'sd8192; acc_in = 16'sd300; in_valid = 1'b1;
      wait_ready("mid_rst");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_ready", in_ready, 0);
      check("mid_rst_y_out", y_out, 0);
      check("mid_rst_z_res", z_res, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_ready_after", in_ready, 1);
      check("mid_rst_valid_after", out_valid, 0);
      $display("[TB] mid_rst aborted during iteration 5");
      do_op("after_rst", 16'sd4096, 16'sd4096, 16'sd0, 2048, 2);

      // Modular wrap, no saturation
      do_op("wrap", 16'sd8192, 16'sd8192, 16'sd32767, -24577, 14);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cordic_lin_mac_seq.md
# cordic_lin_mac_seq

Sequencer for an iterative linear-mode CORDIC multiply-accumulate, y = acc + x·z. It time-multiplexes a single `add_sub` adder/subtractor between the y-update and z-update of each iteration, trading latency for area. It is the MAC element of the neuron datapath and is fed by the layer controller over a valid/ready handshake.

## Interface
- `WIDTH`, default 15: data words are WIDTH+1 bits, signed two's complement.
- `FRAC`, default 13: fractional bits, so 1.0 = 2^FRAC = 8192.
- `ITERS`, default 14: CORDIC iterations. Legal range is 1..FRAC+1; elaboration fails outside it.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: operands valid.
- `in_ready` output, 1 bit: block idle and able to accept.
- `x_in` input, WIDTH+1 bits: multiplicand.
- `z_in` input, WIDTH+1 bits: multiplier. Convergence requires |z| < 2.0.
- `acc_in` input, WIDTH+1 bits: accumulator seed.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: consumer accepts the result.
- `y_out` output, WIDTH+1 bits: acc + x·z.
- `z_res` output, WIDTH+1 bits: residual z, for debug.

## Operation
- FSM states: IDLE, Y_UPD, Z_UPD, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: load x_r←x_in, y_r←acc_in, z_r←z_in, i←0; go to Y_UPD.
- Y_UPD:
  - Shared adder: a=y_r, b=x_r>>>i (arithmetic shift), sel=z_r[MSB]. z<0 subtracts; z≥0, including 0, adds.
  - y_r←out; d_r←z_r[MSB]; go to Z_UPD.
- Z_UPD:
  - Adder: a=z_r, b=1<<(FRAC−i), sel=~d_r. Subtract if z was ≥0, add if z was <0.
  - z_r←out.
  - If i==ITERS−1, go to DONE; else i←i+1 and go to Y_UPD.
- DONE:
  - `out_valid`=1; `y_out`=y_r; `z_res`=z_r.
  - On `out_ready`, go to IDLE.
- Arithmetic is modular (WIDTH+1 bits): no saturation and no overflow flag. Wrap-around is the required behaviour.
- `y_out`/`z_res` hold their last value outside DONE; they are not cleared on handoff.
- Accuracy: |y_out − (acc + x·z)| ≤ ITERS LSB, for |z| < 2.0 and no wrap.

## Timing
- Reset values (`rst_n` low, asynchronous):
  - state=IDLE; all registers 0.
  - `out_valid`=0; `y_out`=0; `z_res`=0.
  - `in_ready`=0 while `rst_n` low, 1 from the first cycle after release.
- Accept occurs on an edge with `in_valid`&&`in_ready`. `out_valid` rises exactly 2·ITERS cycles later (28 at default).
- `in_ready` drops the cycle after accept and stays low until DONE is left.
- In DONE:
  - `in_valid` is ignored (`in_ready`=0), even if `out_ready` is high in the same cycle.
  - The next accept is possible no earlier than the following cycle, in IDLE.
- Minimum initiation interval: 2·ITERS+2 cycles (30 at default).
- `out_valid`, `y_out` and `z_res` stay stable while `out_ready` is low; unbounded backpressure is allowed.
- Reset mid-operation aborts immediately; no partial result is emitted.
- Input operands are sampled only at accept; later changes have no effect.

## Structure
- Shared package `cordic_pkg`:
  - State enum `lin_mac_state_t`.
  - Default FRAC/ITERS constants.
  - Iteration-counter width function clog2(ITERS).
- Exactly one sub-module: a single `add_sub` instance (WIDTH passed through).
  - Operand/sel muxing lives in this block.
  - No second adder; the shift and 2^-i constant are combinational.

## Test plan
- x=4096 (0.5), z=4096, acc=0 -> `y_out`=2048±2; `out_valid` exactly 28 cycles after accept.
- x=−8192 (−1.0), z=6144 (0.75), acc=8192 -> `y_out`=2048±14; z=0, acc=1234, x=5000 -> `y_out`=1234±14.
- `out_ready` low 10 cycles in DONE with `in_valid` held high -> `y_out` stable, `in_ready`=0 throughout, no second accept until after the handoff.
- `in_valid` and `out_ready` tied high, 4 ops -> results spaced exactly 30 cycles apart, each matching its operand set.
- `rst_n` pulsed low during iteration 5 -> `out_valid`=0 immediately, `in_ready`=1 after release, next op (x=4096, z=4096, acc=0) gives 2048±2.
- acc=32767, x=8192, z=8192 -> `y_out`=−24577±14 (modular wrap, no saturation).
